// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for pipe_stage_reg.
// Holds the stage state enum and the occupancy width.
// The SKID state is only reachable when PIPE_STAGE_SKID_EN is defined.
package pipe_pkg;

    // Width of the occupancy output (counts 0..2).
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Number of live payloads held in a given state.
    function automatic logic [OCC_W-1:0] state_occ(input pipe_state_e st);
        case (st)
            FULL:    state_occ = 2'd1;
            SKID:    state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one WIDTH-bit payload register with load enable.
// Updates on the falling edge of CLK; asynchronous active-high reset to RESET_VALUE.
module pipe_skid_slot #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Payload storage: captures d when load is high.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register, falling-edge clocked.
// Macro PIPE_STAGE_SKID_EN adds a skid slot so in_ready comes from a register;
// without it the stage holds one payload and in_ready is combinational.
// out_data carries NOP_VALUE whenever no payload is live.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    pipe_state_e      state_q, state_d;
    logic             tx_in, tx_out;
    logic             main_load;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;

    // in_ready is registered: it looks at where the FSM is going, never at out_ready.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d != SKID);
        end
    end

    assign in_ready = in_ready_q;

    pipe_skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (NOP_VALUE)
    ) u_skid (
        .CLK  (CLK),
        .RST  (RST),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );
`else
    // Single-slot stage: accept when empty or when the held payload leaves this cycle.
    always_comb begin
        in_ready = !RST && (!out_valid || out_ready);
    end
`endif

    assign tx_in  = in_valid && in_ready;
    assign tx_out = out_valid && out_ready;

    // Next-state and register load selection; flush overrides every transfer.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_next = NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
        skid_load = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (tx_in) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                    main_next = in_data;
                end
            end
            FULL: begin
                if (tx_in && tx_out) begin
                    main_load = 1'b1;
                    main_next = in_data;
                end else if (tx_out) begin
                    // Draining to empty puts the bubble back on out_data.
                    state_d   = EMPTY;
                    main_load = 1'b1;
                    main_next = NOP_VALUE;
                end
`ifdef PIPE_STAGE_SKID_EN
                else if (tx_in) begin
                    state_d   = SKID;
                    skid_load = 1'b1;
                end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            SKID: begin
                if (tx_out) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                    main_next = skid_q;
                end
            end
`endif
            default: begin
                state_d   = EMPTY;
                main_load = 1'b1;
                main_next = NOP_VALUE;
            end
        endcase

        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b1;
            main_next = NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_load = 1'b0;
`endif
        end
    end

    // State register.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (NOP_VALUE)
    ) u_main (
        .CLK  (CLK),
        .RST  (RST),
        .load (main_load),
        .d    (main_next),
        .q    (main_q)
    );

    // Outputs derive directly from the state and main register.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        occupancy = state_occ(state_q);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (WIDTH=32, NOP_VALUE=0x13).
// Covers both builds: the skid-specific sequences sit under PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b1;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flush;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    // Falling (active) edges at t = 5, 15, 25, ...
    always #5 CLK = ~CLK;

    pipe_stage_reg #(
        .WIDTH     (32),
        .NOP_VALUE (NOP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one active edge; inputs change and outputs are sampled 1 ns later.
    task automatic edge_step();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_valid"}, out_valid, 1'b0);
        check_eq({tag, "_data"}, out_data, NOP);
        check_eq({tag, "_occ"}, occupancy, 2'd0);
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, before and across clock edges.
        #2;
        check_empty("rst0");
        check_eq("rst0_in_ready", in_ready, 1'b0);
        edge_step();
        edge_step();
        check_empty("rst1");
        check_eq("rst1_in_ready", in_ready, 1'b0);
        RST = 1'b0;
        edge_step();
        check_eq("rel_in_ready", in_ready, 1'b1);
        check_empty("rel");

        // Full-throughput stream 1..8.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = i;
            edge_step();
            check_eq($sformatf("stream%0d_data", i), out_data, i);
            check_eq($sformatf("stream%0d_valid", i), out_valid, 1'b1);
            check_eq($sformatf("stream%0d_occ", i), occupancy, 2'd1);
        end
        in_valid = 1'b0;
        edge_step();
        check_empty("drain");

`ifdef PIPE_STAGE_SKID_EN
        // Fill main and skid while stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        edge_step();
        check_eq("sk_a_data", out_data, 32'hA);
        check_eq("sk_a_occ", occupancy, 2'd1);
        check_eq("sk_a_ready", in_ready, 1'b1);
        in_data = 32'hB;
        edge_step();
        check_eq("sk_b_occ", occupancy, 2'd2);
        check_eq("sk_b_ready", in_ready, 1'b0);
        check_eq("sk_b_data", out_data, 32'hA);
        // Offer 0xD while not ready: must not be taken.
        in_data   = 32'hD;
        out_ready = 1'b1;
        #1;
        check_eq("sk_ready_reg", in_ready, 1'b0);
        edge_step();
        check_eq("sk_out_b", out_data, 32'hB);
        check_eq("sk_out_b_occ", occupancy, 2'd1);
        in_valid = 1'b0;
        edge_step();
        check_empty("sk_drain");

        // Flush at occupancy 2 with a payload offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        edge_step();
        in_data = 32'hB;
        edge_step();
        check_eq("fl_pre_occ", occupancy, 2'd2);
        flush   = 1'b1;
        in_data = 32'hC;
        edge_step();
        check_empty("fl");
        flush    = 1'b0;
        in_valid = 1'b0;
        edge_step();
        check_empty("fl_after");

        // Asynchronous reset between edges at occupancy 2.
        in_valid = 1'b1;
        in_data  = 32'hA;
        edge_step();
        in_data = 32'hB;
        edge_step();
        in_valid = 1'b0;
        check_eq("ar_pre_occ", occupancy, 2'd2);
        #2;
        RST = 1'b1;
        #1;
        check_empty("ar");
        check_eq("ar_in_ready", in_ready, 1'b0);
        RST = 1'b0;
        edge_step();
        check_eq("ar_rel_ready", in_ready, 1'b1);
        check_empty("ar_rel");
`else
        // One held payload: stall drops in_ready combinationally.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        edge_step();
        check_eq("ns_a_data", out_data, 32'hA);
        check_eq("ns_a_occ", occupancy, 2'd1);
        check_eq("ns_stall_ready", in_ready, 1'b0);
        in_data = 32'hB;
        edge_step();
        check_eq("ns_hold_data", out_data, 32'hA);
        check_eq("ns_hold_occ", occupancy, 2'd1);
        out_ready = 1'b1;
        #1;
        check_eq("ns_comb_ready", in_ready, 1'b1);
        edge_step();
        check_eq("ns_b_data", out_data, 32'hB);
        in_valid = 1'b0;
        edge_step();
        check_empty("ns_drain");

        // Flush with a held payload and one offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        edge_step();
        flush   = 1'b1;
        in_data = 32'hC;
        edge_step();
        check_empty("fl");
        flush    = 1'b0;
        in_valid = 1'b0;
        edge_step();
        check_empty("fl_after");

        // Asynchronous reset between edges with one payload held.
        in_valid = 1'b1;
        in_data  = 32'hA;
        edge_step();
        in_valid = 1'b0;
        check_eq("ar_pre_occ", occupancy, 2'd1);
        #2;
        RST = 1'b1;
        #1;
        check_empty("ar");
        check_eq("ar_in_ready", in_ready, 1'b0);
        RST = 1'b0;
        edge_step();
        check_eq("ar_rel_ready", in_ready, 1'b1);
        check_empty("ar_rel");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
